delay_gate: RTL and testbench
=============================

DELAY_GATE -- requirements
Module: delay_gate

Interface
REQ-001 Parameter FN, default 0: gate function select; 0 = (a & b) | c, 1 = a & b & c, 2 = a | b | c, 3 = a ^ b ^ c, 4 = majority(a,b,c); other values are illegal and are flagged at elaboration.
REQ-002 Parameter DELAY, default 4: delay in clock cycles; legal range 1..64; values outside the range are flagged at elaboration.
REQ-003 Parameter INERTIAL, default 0: 0 = transport delay, 1 = inertial delay.
REQ-004 Ports: clk  in  1  sole clock, rising-edge active.
REQ-005 Ports: rst_n  in  1  synchronous, active-low reset.
REQ-006 Ports: a  in  1  gate input A.
REQ-007 Ports: b  in  1  gate input B.
REQ-008 Ports: c  in  1  gate input C.
REQ-009 Ports: y  out  1  delayed gate result, registered.
REQ-010 Ports: y_valid  out  1  high once y reflects sampled inputs, registered.

Function
REQ-011 g SHALL be the combinational FN result of a, b and c, sampled on every rising clk edge while rst_n is high.
REQ-012 Transport mode: g sampled at edge k SHALL appear on y immediately after edge k+DELAY-1, through exactly DELAY register stages.
REQ-013 Transport mode: every pulse on g, including a 1-cycle pulse, SHALL reproduce on y with identical width.
REQ-014 Inertial mode: a counter cnt, ceil(log2(DELAY+1)) bits, SHALL track samples in which g differs from y.
REQ-015 Inertial mode: at each edge, if g equals y, cnt SHALL clear to 0.
REQ-016 Inertial mode: if g differs from y, cnt SHALL increment; when the incremented value equals DELAY, y SHALL load g and cnt SHALL clear in the same edge.
REQ-017 Inertial mode: a g pulse shorter than DELAY cycles SHALL NOT appear on y.
REQ-018 Inertial mode: a g pulse of N ≥ DELAY cycles SHALL appear on y as an N-cycle pulse with latency DELAY-1 edges after its first sample.
REQ-019 Inertial mode with DELAY = 1: y SHALL equal g registered once, with no filtering.
REQ-020 y_valid SHALL rise immediately after the DELAY-th sampling edge following reset release and stay high until the next reset, in both modes.
REQ-021 y SHALL be the only delayed signal; a, b and c SHALL NOT be individually delayed.

Reset
REQ-022 While rst_n is low at a rising edge, every pipeline stage, y, cnt and y_valid SHALL load 0.
REQ-023 Reset asserted mid-operation SHALL discard all in-flight samples; no pre-reset value SHALL reach y after release.
REQ-024 The first sample after release SHALL be taken at the first rising edge with rst_n high.
REQ-025 No asynchronous reset path SHALL exist.

Structure
REQ-026 FN encodings (FN_AO21=0, FN_AND3=1, FN_OR3=2, FN_XOR3=3, FN_MAJ3=4) and the DELAY limits SHALL reside in shared package delay_gate_pkg.
REQ-027 The gate function SHALL be a single sub-module, delay_gate_fn (inputs a, b, c; output g; parameter FN), which is purely combinational.
REQ-028 The transport shift register and the inertial counter SHALL be generate-selected by INERTIAL; unused logic SHALL NOT be built.

Verification
REQ-029 Reset/steady, defaults: rst_n low 2 cycles with abc=001 -> y=0, y_valid=0; release, hold abc=001 -> y=1 and y_valid=1 immediately after the 4th edge.
REQ-030 Transport, DELAY=4: abc=000, then abc=001 for exactly 1 cycle at edge k -> y=1 for exactly 1 cycle immediately after edge k+3, else 0.
REQ-031 Inertial, DELAY=4: abc=001 for 3 cycles -> y stays 0; abc=001 for 4 cycles starting at edge k -> y=1 from edge k+3 for exactly 4 cycles.
REQ-032 Function sweep, FN=0..4, DELAY=2: apply all 8 abc combinations, each held 3 cycles -> y matches the truth table 1 edge after each change (e.g. FN=4, abc=110 -> 1; FN=3, abc=111 -> 1).
REQ-033 Mid-operation reset, transport, DELAY=4: pipeline full of 1s, rst_n low 1 edge -> y=0 and y_valid=0 next edge; after release with abc=000 -> y stays 0 and y_valid rises after the 4th edge.
REQ-034 Edge case, DELAY=1, both modes: abc toggles 000/001 every cycle -> y follows g one register stage later with no suppression.

Source files
------------

// File: rtl/delay_gate_pkg.sv
// Shared definitions for delay_gate: gate function encodings and delay limits.
package delay_gate_pkg;

  localparam int FN_AO21 = 0;
  localparam int FN_AND3 = 1;
  localparam int FN_OR3  = 2;
  localparam int FN_XOR3 = 3;
  localparam int FN_MAJ3 = 4;

  localparam int DELAY_MIN = 1;
  localparam int DELAY_MAX = 64;

  function automatic bit fn_legal(input int fn);
    return (fn >= FN_AO21) && (fn <= FN_MAJ3);
  endfunction

  function automatic bit delay_legal(input int d);
    return (d >= DELAY_MIN) && (d <= DELAY_MAX);
  endfunction

endpackage

// File: rtl/delay_gate_fn.sv
// Purely combinational three-input gate; FN picks the boolean function.
module delay_gate_fn
  import delay_gate_pkg::*;
#(
  parameter int FN = FN_AO21
) (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic g
);

  always_comb begin
    g = 1'b0;
    case (FN)
      FN_AO21: g = (a & b) | c;
      FN_AND3: g = a & b & c;
      FN_OR3:  g = a | b | c;
      FN_XOR3: g = a ^ b ^ c;
      FN_MAJ3: g = (a & b) | (a & c) | (b & c);
      default: g = 1'b0;
    endcase
  end

endmodule

// File: rtl/delay_gate.sv
// Gate result of a/b/c delayed by DELAY cycles, as a transport shift
// register or as an inertial (pulse-rejecting) filter.
module delay_gate
  import delay_gate_pkg::*;
#(
  parameter int FN       = FN_AO21,
  parameter int DELAY    = 4,
  parameter int INERTIAL = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic c,
  output logic y,
  output logic y_valid
);

  localparam int CNT_W = $clog2(DELAY + 1);

  if (!fn_legal(FN)) begin : g_bad_fn
    $error("delay_gate: illegal FN value %0d", FN);
  end
  if (!delay_legal(DELAY)) begin : g_bad_delay
    $error("delay_gate: DELAY %0d outside %0d..%0d", DELAY, DELAY_MIN, DELAY_MAX);
  end
  if ((INERTIAL != 0) && (INERTIAL != 1)) begin : g_bad_mode
    $error("delay_gate: illegal INERTIAL value %0d", INERTIAL);
  end

  logic g;

  delay_gate_fn #(.FN(FN)) u_fn (
    .a (a),
    .b (b),
    .c (c),
    .g (g)
  );

  // y_valid rises on the DELAY-th sampling edge after reset release
  logic [CNT_W-1:0] vld_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_cnt <= '0;
      y_valid <= 1'b0;
    end else if (!y_valid) begin
      if (vld_cnt == CNT_W'(DELAY - 1)) y_valid <= 1'b1;
      vld_cnt <= vld_cnt + CNT_W'(1);
    end
  end

  if (INERTIAL == 0) begin : g_transport
    // stage 0 takes g; stage DELAY-1 drives y
    logic [DELAY-1:0] sr_p;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sr_p <= '0;
      end else begin
        sr_p[0] <= g;
        for (int i = 1; i < DELAY; i++) sr_p[i] <= sr_p[i-1];
      end
    end

    assign y = sr_p[DELAY-1];
  end else begin : g_inertial
    // cnt counts consecutive samples disagreeing with y; y follows after DELAY of them
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             y_p0;

    assign cnt_inc = cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt  <= '0;
        y_p0 <= 1'b0;
      end else if (g == y_p0) begin
        cnt <= '0;
      end else if (cnt_inc == CNT_W'(DELAY)) begin
        y_p0 <= g;
        cnt  <= '0;
      end else begin
        cnt <= cnt_inc;
      end
    end

    assign y = y_p0;
  end

endmodule

// File: tb/tb_delay_gate.sv
// Self-checking bench for delay_gate: directed scenarios plus randomized
// stimulus against a sample-history reference model.
module tb_delay_gate;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, a, b, c;
  logic y_def, v_def, y_in4, v_in4, y_t1, v_t1, y_i1, v_i1, y_i3, v_i3;
  logic [4:0] y_fn, v_fn;

  int checks = 0;
  int errors = 0;

  delay_gate u_def (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .y(y_def), .y_valid(v_def)
  );
  delay_gate #(.FN(0), .DELAY(4), .INERTIAL(1)) u_in4 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .y(y_in4), .y_valid(v_in4)
  );
  delay_gate #(.FN(0), .DELAY(1), .INERTIAL(0)) u_t1 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .y(y_t1), .y_valid(v_t1)
  );
  delay_gate #(.FN(0), .DELAY(1), .INERTIAL(1)) u_i1 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .y(y_i1), .y_valid(v_i1)
  );
  delay_gate #(.FN(3), .DELAY(3), .INERTIAL(1)) u_i3 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .y(y_i3), .y_valid(v_i3)
  );
  for (genvar f = 0; f < 5; f++) begin : g_fn
    delay_gate #(.FN(f), .DELAY(2), .INERTIAL(0)) u_dut (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .y(y_fn[f]), .y_valid(v_fn[f])
    );
  end

  // Truth tables indexed by {a,b,c}
  function automatic logic tt(input int fn, input logic [2:0] abc);
    logic [7:0] t;
    case (fn)
      0: t = 8'hEA;
      1: t = 8'h80;
      2: t = 8'hFE;
      3: t = 8'h96;
      4: t = 8'hE8;
      default: t = 8'h00;
    endcase
    return t[abc];
  endfunction

  // Reference model: history of input samples since the last reset
  logic [2:0] hist[$];
  logic m_in4, m_i1, m_i3;

  function automatic logic trans_y(input int fn, input int d);
    if (hist.size() < d) return 1'b0;
    return tt(fn, hist[hist.size() - d]);
  endfunction

  function automatic logic hist_full(input int d);
    return hist.size() >= d;
  endfunction

  // Inertial output flips once the latest d samples all disagree with it
  function automatic logic inert_next(input logic cur, input int fn, input int d);
    if (hist.size() < d) return cur;
    for (int i = 0; i < d; i++)
      if (tt(fn, hist[hist.size() - 1 - i]) == cur) return cur;
    return ~cur;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      hist.delete();
      m_in4 <= 1'b0;
      m_i1  <= 1'b0;
      m_i3  <= 1'b0;
    end else begin
      hist.push_back({a, b, c});
      if (hist.size() > 80) void'(hist.pop_front());
      m_in4 <= inert_next(m_in4, 0, 4);
      m_i1  <= inert_next(m_i1, 0, 1);
      m_i3  <= inert_next(m_i3, 3, 3);
    end
  end

  task automatic test_reset;
    rst_n = 1'b0;
    {a, b, c} = 3'b001;
    repeat (2) @(negedge clk);
    checks++;
    if (y_def !== 1'b0) begin
      errors++; $display("FAIL reset_y: got %b want 0", y_def);
    end
    checks++;
    if ({v_def, v_in4, v_t1, v_i1, v_i3, v_fn} !== 10'b0) begin
      errors++; $display("FAIL reset_valid: got %b want 0", {v_def, v_in4, v_t1, v_i1, v_i3, v_fn});
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      checks++;
      if (y_def !== (i >= 4)) begin
        errors++; $display("FAIL steady_y edge %0d: got %b want %b", i, y_def, (i >= 4));
      end
      checks++;
      if (v_def !== (i >= 4)) begin
        errors++; $display("FAIL steady_valid edge %0d: got %b want %b", i, v_def, (i >= 4));
      end
    end
  endtask

  task automatic test_transport_pulse;
    {a, b, c} = 3'b000;
    repeat (6) @(negedge clk);
    {a, b, c} = 3'b001;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) {a, b, c} = 3'b000;
      checks++;
      if (y_def !== (i == 3)) begin
        errors++; $display("FAIL transport_pulse edge k+%0d: got %b want %b", i, y_def, (i == 3));
      end
    end
  endtask

  task automatic test_inertial;
    {a, b, c} = 3'b000;
    repeat (8) @(negedge clk);
    {a, b, c} = 3'b001;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (i == 2) {a, b, c} = 3'b000;
      checks++;
      if (y_in4 !== 1'b0) begin
        errors++; $display("FAIL inertial_short edge k+%0d: got %b want 0", i, y_in4);
      end
    end
    {a, b, c} = 3'b001;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 3) {a, b, c} = 3'b000;
      checks++;
      if (y_in4 !== (i >= 3 && i <= 6)) begin
        errors++; $display("FAIL inertial_pass edge k+%0d: got %b want %b", i, y_in4, (i >= 3 && i <= 6));
      end
    end
  endtask

  task automatic test_fn_sweep;
    for (int v = 0; v < 8; v++) begin
      {a, b, c} = 3'(v);
      for (int h = 0; h < 3; h++) begin
        @(negedge clk);
        if (h >= 1) begin
          for (int f = 0; f < 5; f++) begin
            checks++;
            if (y_fn[f] !== tt(f, 3'(v))) begin
              errors++; $display("FAIL fn_sweep fn=%0d abc=%03b: got %b want %b", f, 3'(v), y_fn[f], tt(f, 3'(v)));
            end
          end
        end
      end
    end
    checks++;
    if (v_fn !== 5'b11111) begin
      errors++; $display("FAIL fn_sweep_valid: got %b want 11111", v_fn);
    end
  endtask

  task automatic test_mid_reset;
    {a, b, c} = 3'b001;
    repeat (5) @(negedge clk);
    checks++;
    if (y_def !== 1'b1) begin
      errors++; $display("FAIL mid_reset_full: got %b want 1", y_def);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({y_def, v_def} !== 2'b00) begin
      errors++; $display("FAIL mid_reset_clear: got y/valid %b want 00", {y_def, v_def});
    end
    rst_n = 1'b1;
    {a, b, c} = 3'b000;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      checks++;
      if (y_def !== 1'b0) begin
        errors++; $display("FAIL mid_reset_flush edge %0d: got %b want 0", i, y_def);
      end
      checks++;
      if (v_def !== (i >= 4)) begin
        errors++; $display("FAIL mid_reset_valid edge %0d: got %b want %b", i, v_def, (i >= 4));
      end
    end
  endtask

  task automatic test_delay1;
    for (int i = 0; i < 12; i++) begin
      {a, b, c} = {2'b00, (i % 2) == 1};
      @(negedge clk);
      checks++;
      if (y_t1 !== ((i % 2) == 1)) begin
        errors++; $display("FAIL delay1_transport step %0d: got %b want %b", i, y_t1, (i % 2) == 1);
      end
      checks++;
      if (y_i1 !== ((i % 2) == 1)) begin
        errors++; $display("FAIL delay1_inertial step %0d: got %b want %b", i, y_i1, (i % 2) == 1);
      end
    end
  endtask

  task automatic test_random;
    logic [9:0] obs, exp;
    string names[10] = '{"y_def", "v_def", "y_in4", "v_in4", "y_t1",
                         "v_t1", "y_i1", "v_i1", "y_i3", "v_i3"};
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      obs = {y_def, v_def, y_in4, v_in4, y_t1, v_t1, y_i1, v_i1, y_i3, v_i3};
      exp = {trans_y(0, 4), hist_full(4), m_in4, hist_full(4), trans_y(0, 1),
             hist_full(1), m_i1, hist_full(1), m_i3, hist_full(3)};
      for (int k = 0; k < 10; k++) begin
        checks++;
        if (obs[9-k] !== exp[9-k]) begin
          errors++; $display("FAIL rand_%s cycle %0d: got %b want %b", names[k], n, obs[9-k], exp[9-k]);
        end
      end
      for (int f = 0; f < 5; f++) begin
        checks++;
        if ({y_fn[f], v_fn[f]} !== {trans_y(f, 2), hist_full(2)}) begin
          errors++; $display("FAIL rand_fn%0d cycle %0d: got y/valid %b%b want %b%b",
                             f, n, y_fn[f], v_fn[f], trans_y(f, 2), hist_full(2));
        end
      end
      {a, b, c} = 3'($urandom_range(0, 7));
      rst_n = ($urandom_range(0, 39) != 0);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_transport_pulse();
    test_inertial();
    test_fn_sweep();
    test_mid_reset();
    test_delay1();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
